ram_slot_sequencer: RTL and testbench

RAM_SLOT_SEQUENCER -- requirements
Module: ram_slot_sequencer

---
 rtl/ram_slot_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ram_slot_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_slot_sequencer.sv
// ram_slot_sequencer
// Shares a single synchronous RAM between a CPU port and a video port using
// alternating RAM_en slots. Slot parity 0 belongs to video and parity 1 to the
// CPU. A granted access takes three cycles: ACCESS, where the RAM is strobed,
// CAPTURE, where the read data is returned, and a one-cycle ack/valid pulse
// once the sequencer is back in IDLE.
// Build option: define SLOT_STEAL_EN to let the non-owner take a slot whose
// owner is not requesting. Without it, the two ports strictly alternate.

module ram_slot_sequencer (
  input  logic        PIXELCLK,
  input  logic        nRESET,
  input  logic        RAM_en,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_valid,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  logic parity_r;       // 0 = video slot, 1 = CPU slot
  logic own_cpu_r;      // access in flight belongs to the CPU
  logic own_we_r;       // access in flight is a CPU write
  logic owner_req_s;
  logic steal_req_s;
  logic grant_s;
  logic grant_cpu_s;

  // Slot arbitration: decide whether this RAM_en cycle starts an access and for whom.
  always_comb begin
    owner_req_s = 1'b0;
    steal_req_s = 1'b0;
    grant_s     = 1'b0;
    grant_cpu_s = 1'b0;
    if (parity_r) begin
      owner_req_s = cpu_req;
`ifdef SLOT_STEAL_EN
      steal_req_s = vid_req;
`else
      steal_req_s = 1'b0;
`endif
    end else begin
      owner_req_s = vid_req;
`ifdef SLOT_STEAL_EN
      steal_req_s = cpu_req;
`else
      steal_req_s = 1'b0;
`endif
    end
    if ((state_r == IDLE) && RAM_en && (owner_req_s || steal_req_s)) begin
      grant_s = 1'b1;
      // The owner wins when it asks; otherwise the slot goes to the other side.
      if (owner_req_s) begin
        grant_cpu_s = parity_r;
      end else begin
        grant_cpu_s = ~parity_r;
      end
    end else begin
      grant_s     = 1'b0;
      grant_cpu_s = 1'b0;
    end
  end

  // Next-state logic: one cycle in each of ACCESS and CAPTURE after a grant.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = CAPTURE;
      CAPTURE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register with synchronous reset; an in-flight access is dropped.
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Slot parity flips on every RAM_en strobe, whatever the sequencer is doing.
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      parity_r <= 1'b0;
    end else if (RAM_en) begin
      parity_r <= ~parity_r;
    end else begin
      parity_r <= parity_r;
    end
  end

  // Registered RAM strobes, latched request fields, read-data capture and ack pulses.
  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 16'h0000;
      ram_wdata <= 8'h00;
      cpu_rdata <= 8'h00;
      vid_rdata <= 8'h00;
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      own_cpu_r <= 1'b0;
      own_we_r  <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            // Everything the access needs is captured here, so later
            // request-side changes cannot disturb it.
            ram_cs    <= 1'b1;
            ram_we    <= grant_cpu_s & cpu_we;
            ram_wdata <= cpu_wdata;
            own_cpu_r <= grant_cpu_s;
            own_we_r  <= grant_cpu_s & cpu_we;
            if (grant_cpu_s) begin
              ram_addr <= cpu_addr;
            end else begin
              ram_addr <= {1'b0, vid_addr};
            end
          end else begin
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
          end
        end
        ACCESS: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
        end
        CAPTURE: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          if (own_cpu_r) begin
            if (!own_we_r) begin
              cpu_rdata <= ram_rdata;
            end else begin
              cpu_rdata <= cpu_rdata;
            end
            cpu_ack <= 1'b1;
          end else begin
            vid_rdata <= ram_rdata;
            vid_valid <= 1'b1;
          end
        end
        default: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_slot_sequencer.sv
// Bench for ram_slot_sequencer: directed slots followed by random traffic.
// A reference model predicts each RAM strobe and each ack/valid from the slot
// rules; a negedge monitor compares what the DUT presents against the queues.
// Define SLOT_STEAL_EN on the command line to check the slot-stealing build.

module tb_ram_slot_sequencer;

  logic        PIXELCLK = 1'b0;
  logic        nRESET;
  logic        RAM_en;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [7:0]  vid_rdata;
  logic        vid_valid;
  logic        ram_cs;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

`ifdef SLOT_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  ram_slot_sequencer dut (
    .PIXELCLK (PIXELCLK),
    .nRESET   (nRESET),
    .RAM_en   (RAM_en),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_rdata(vid_rdata),
    .vid_valid(vid_valid),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 PIXELCLK = ~PIXELCLK;

  int cyc = 0;
  always @(posedge PIXELCLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct { int due; bit cpu; logic [7:0] data; } resp_t;
  typedef struct { int due; logic [15:0] addr; bit we; logic [7:0] wdata; } acc_t;
  resp_t resp_q[$];
  acc_t  acc_q[$];

  // Reference model state
  logic [7:0] model_mem [0:65535];
  bit         mpar;
  int         mlast;
  logic [7:0] m_cpu_rd;
  logic [7:0] m_vid_rd;

  function automatic logic [7:0] seed_byte(input int a);
    if (a == 32'h3000) return 8'hA5;
    else return 8'(a * 37 + (a >>> 8) * 11 + 3);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous RAM: read data appears the cycle after the strobe.
  logic [7:0] ram_mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram_mem[i] = seed_byte(i);
    ram_rdata = 8'h00;
    forever begin
      @(posedge PIXELCLK);
      if (ram_cs === 1'b1) begin
        ram_rdata <= ram_mem[ram_addr];
        if (ram_we === 1'b1) ram_mem[ram_addr] = ram_wdata;
      end else begin
        ram_rdata <= 8'($urandom);
      end
    end
  end

  // Model step for the inputs about to be sampled at the end of this cycle.
  task automatic model_step();
    resp_t r;
    acc_t  a;
    resp_t keep_r[$];
    acc_t  keep_a[$];
    bit g, to_cpu, owner_req, other_req;
    if (!nRESET) begin
      mpar = 1'b0; mlast = -100; m_cpu_rd = 8'h00; m_vid_rd = 8'h00;
      foreach (resp_q[i]) if (resp_q[i].due <= cyc) keep_r.push_back(resp_q[i]);
      foreach (acc_q[i])  if (acc_q[i].due  <= cyc) keep_a.push_back(acc_q[i]);
      resp_q = keep_r;
      acc_q  = keep_a;
    end else if (RAM_en) begin
      // A new access can only start once the previous one has fully retired.
      if (cyc >= mlast + 3) begin
        owner_req = mpar ? cpu_req : vid_req;
        other_req = mpar ? vid_req : cpu_req;
        g = 1'b0; to_cpu = 1'b0;
        if (owner_req) begin g = 1'b1; to_cpu = mpar; end
        else if (STEAL && other_req) begin g = 1'b1; to_cpu = !mpar; end
        if (g) begin
          mlast = cyc;
          if (to_cpu) begin
            if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
            else m_cpu_rd = model_mem[cpu_addr];
            a = '{cyc + 1, cpu_addr, cpu_we, cpu_wdata};
            r = '{cyc + 3, 1'b1, m_cpu_rd};
          end else begin
            m_vid_rd = model_mem[{1'b0, vid_addr}];
            a = '{cyc + 1, {1'b0, vid_addr}, 1'b0, cpu_wdata};
            r = '{cyc + 3, 1'b0, m_vid_rd};
          end
          acc_q.push_back(a);
          resp_q.push_back(r);
        end
      end
      mpar = !mpar;
    end
  endtask

  // Monitor: compare RAM strobes and ack/valid pulses against the model queues.
  resp_t mr;
  acc_t  ma;
  always @(negedge PIXELCLK) begin
    if (cyc >= 1) begin
      if (ram_cs === 1'b1) begin
        if (acc_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ram_cs: got addr %0h, expected no access (cycle %0d)", ram_addr, cyc);
        end else begin
          ma = acc_q.pop_front();
          check("ram_cs_cycle", 64'(cyc), 64'(ma.due));
          check("ram_addr", 64'(ram_addr), 64'(ma.addr));
          check("ram_we", 64'(ram_we), 64'(ma.we));
          if (ma.we) check("ram_wdata", 64'(ram_wdata), 64'(ma.wdata));
        end
      end else begin
        check("ram_we_idle", 64'(ram_we), 64'd0);
      end
      if (cpu_ack === 1'b1 || vid_valid === 1'b1) begin
        check("ack_exclusive", 64'(cpu_ack & vid_valid), 64'd0);
        if (resp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ack: got cpu_ack=%0b vid_valid=%0b, expected none (cycle %0d)", cpu_ack, vid_valid, cyc);
        end else begin
          mr = resp_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(mr.due));
          check("ack_kind", 64'(cpu_ack), 64'(mr.cpu));
          if (mr.cpu) check("cpu_rdata", 64'(cpu_rdata), 64'(mr.data));
          else check("vid_rdata", 64'(vid_rdata), 64'(mr.data));
        end
      end
    end
  end

  task automatic drive_cycle(input logic en, input logic vr, input logic [14:0] va,
                             input logic cr, input logic cw, input logic [15:0] ca,
                             input logic [7:0] cd);
    RAM_en = en; vid_req = vr; vid_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    model_step();
    @(posedge PIXELCLK);
    #1;
  endtask

  task automatic junk_cycle(input logic en);
    drive_cycle(en, 1'($urandom), 15'($urandom), 1'($urandom), 1'($urandom),
                16'($urandom), 8'($urandom));
  endtask

  // One four-cycle slot: RAM_en on the first cycle, optional extra RAM_en later.
  task automatic run_slot(input logic vr, input logic [14:0] va, input logic cr,
                          input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                          input int force_at);
    drive_cycle(1'b1, vr, va, cr, cw, ca, cd);
    for (int p = 1; p < 4; p++) junk_cycle(p == force_at);
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, 64'({ram_cs, ram_we, ram_addr, ram_wdata, cpu_rdata, vid_rdata,
                     cpu_ack, vid_valid}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) model_mem[i] = seed_byte(i);
    mpar = 1'b0; mlast = -100; m_cpu_rd = 8'h00; m_vid_rd = 8'h00;
    nRESET = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    check_zero_outputs("reset_outputs");
    nRESET = 1'b1;

    // First slot is video: word 16'h3000 holds 8'hA5.
    run_slot(1'b1, 15'h3000, 1'b0, 1'b0, 16'h0000, 8'h00, -1);
    // CPU write then (owner-idle video slot) and CPU read of the same word.
    run_slot(1'b0, 15'h0000, 1'b1, 1'b1, 16'h1234, 8'h5A, -1);
    run_slot(1'b0, 15'h0000, 1'b1, 1'b0, 16'h1234, 8'h00, -1);
    run_slot(1'b0, 15'h0000, 1'b1, 1'b0, 16'h1234, 8'h00, -1);
    // Both ports requesting for eight slots.
    for (int s = 0; s < 8; s++)
      run_slot(1'b1, 15'($urandom_range(16'h1230, 16'h123F)), 1'b1, 1'($urandom),
               16'($urandom_range(16'h1230, 16'h123F)), 8'($urandom), -1);

    // Extra RAM_en during CAPTURE of a CPU read.
    if (mpar != 1'b1) run_slot(1'b1, 15'h0100, 1'b0, 1'b0, 16'h0, 8'h0, -1);
    run_slot(1'b0, 15'h0000, 1'b1, 1'b0, 16'h1234, 8'h00, 2);

    // Reset asserted during CAPTURE of a CPU read.
    if (mpar != 1'b1) run_slot(1'b1, 15'h0200, 1'b0, 1'b0, 16'h0, 8'h0, -1);
    drive_cycle(1'b1, 1'b0, 15'h0, 1'b1, 1'b0, 16'h1234, 8'h00);
    junk_cycle(1'b0);
    nRESET = 1'b0;
    junk_cycle(1'b0);
    nRESET = 1'b1;
    check_zero_outputs("outputs_after_reset");
    junk_cycle(1'b0);
    // Both requesting right after reset: parity 0 must pick video.
    run_slot(1'b1, 15'h3000, 1'b1, 1'b0, 16'h1234, 8'h00, -1);

    // Random traffic with occasional stray RAM_en strobes.
    for (int s = 0; s < 80; s++)
      run_slot(1'($urandom), 15'($urandom_range(16'h1230, 16'h123F)), 1'($urandom),
               1'($urandom), 16'($urandom_range(16'h1230, 16'h123F)), 8'($urandom),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : -1);

    for (int s = 0; s < 3; s++) run_slot(1'b0, 15'h0, 1'b0, 1'b0, 16'h0, 8'h0, -1);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check("acc_queue_drained", 64'(acc_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
